// File: rtl/wb_mon_pkg.sv
// rtl/wb_mon_pkg.sv - shared types and constants for the write-back monitor
package wb_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mon_state_t;

    localparam int XZR_REG = 31;

    // Expected results of the reference LEGv8 programs.
    localparam int          FACT_REG    = 0;
    localparam logic [63:0] FACT_RESULT = 64'h21C3_677C_82B4_0000;
    localparam int          SORT_REG    = 9;
    localparam int          SORT_LEN    = 5;

    function automatic logic [63:0] sort_result(input int idx);
        case (idx)
            0:       sort_result = 64'h1;
            1:       sort_result = 64'h2;
            2:       sort_result = 64'h27;
            3:       sort_result = 64'h45;
            4:       sort_result = 64'h99;
            default: sort_result = 64'h0;
        endcase
    endfunction

endpackage

// File: rtl/wb_exp_table.sv
// rtl/wb_exp_table.sv - expected (register, data) table with hit tracking
module wb_exp_table
    import wb_mon_pkg::*;
#(
    parameter int WORD   = 64,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [REG_AW-1:0]        wr_reg,
    input  logic [WORD-1:0]          wr_data,
    input  logic                     clear_hits,
    input  logic                     set_hit,
    input  logic [$clog2(DEPTH)-1:0] set_idx,
    input  logic [$clog2(DEPTH):0]   count,
    input  logic [REG_AW-1:0]        ev_reg,
    input  logic [WORD-1:0]          ev_data,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [REG_AW-1:0]        rd_reg,
    output logic [WORD-1:0]          rd_data,
    output logic                     match_any,
    output logic [$clog2(DEPTH)-1:0] match_idx,
    output logic [$clog2(DEPTH)-1:0] unhit_idx
);
    localparam int IW = $clog2(DEPTH);

    logic [REG_AW-1:0] reg_mem  [DEPTH];
    logic [WORD-1:0]   data_mem [DEPTH];
    logic [DEPTH-1:0]  hit;

    // Table contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            reg_mem[wr_idx]  <= wr_reg;
            data_mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit <= '0;
        end else if (clear_hits) begin
            hit <= '0;
        end else if (set_hit) begin
            hit[set_idx] <= 1'b1;
        end
    end

    assign rd_reg  = reg_mem[rd_idx];
    assign rd_data = data_mem[rd_idx];

    // Scan from the top so the lowest qualifying index is the last one written.
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        unhit_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (i < int'(count) && !hit[i]) begin
                unhit_idx = IW'(i);
                if (reg_mem[i] == ev_reg && data_mem[i] == ev_data) begin
                    match_any = 1'b1;
                    match_idx = IW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/wb_monitor.sv
// rtl/wb_monitor.sv - write-back stream checker with ordered/unordered matching
module wb_monitor
    import wb_mon_pkg::*;
#(
    parameter int WORD    = 64,
    parameter int REG_AW  = 5,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 500,
    parameter int ORDERED = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     exp_wr_en,
    input  logic [$clog2(DEPTH)-1:0] exp_wr_idx,
    input  logic [REG_AW-1:0]        exp_wr_reg,
    input  logic [WORD-1:0]          exp_wr_data,
    input  logic [$clog2(DEPTH):0]   exp_count,
    input  logic                     start,
    input  logic                     wb_en,
    input  logic [REG_AW-1:0]        wb_reg,
    input  logic [WORD-1:0]          wb_data,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic                     fail,
    output logic [$clog2(DEPTH):0]   match_cnt,
    output logic [15:0]              mismatch_cnt,
    output logic [31:0]              cycle_cnt,
    output logic [$clog2(DEPTH)-1:0] fail_idx,
    output logic [WORD-1:0]          fail_data
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    mon_state_t        state;
    logic [CW-1:0]     count_q;
    logic [IW-1:0]     ptr;
    logic              tbl_wr;
    logic              clear_hits;
    logic              set_hit;
    logic [REG_AW-1:0] rd_reg;
    logic [WORD-1:0]   rd_data;
    logic              match_any;
    logic [IW-1:0]     match_idx;
    logic [IW-1:0]     unhit_idx;
    logic              ev;
    logic              hit_ok;
    logic              miss;
    logic              bad_data;
    logic              completing;
    logic              timed_out;

    assign tbl_wr     = exp_wr_en && state != RUN;
    assign clear_hits = start && state != RUN;
    assign ev         = state == RUN && wb_en && wb_reg != REG_AW'(XZR_REG);
    assign set_hit    = (ORDERED == 0) && hit_ok;
    assign completing = hit_ok && (match_cnt + CW'(1) == count_q);
    assign timed_out  = (TIMEOUT != 0) && cycle_cnt == 32'(TIMEOUT - 1);
    assign busy       = state == RUN;
    assign done       = state == DONE;

    // Ordered mode only looks at the entry under the pointer; writes to other
    // registers are not events for it.
    always_comb begin
        hit_ok   = 1'b0;
        miss     = 1'b0;
        bad_data = 1'b0;
        if (ORDERED != 0) begin
            hit_ok   = ev && rd_reg == wb_reg && rd_data == wb_data;
            bad_data = ev && rd_reg == wb_reg && rd_data != wb_data;
            miss     = bad_data;
        end else begin
            hit_ok = ev && match_any;
            miss   = ev && !match_any;
        end
    end

    wb_exp_table #(
        .WORD   (WORD),
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH)
    ) u_table (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (tbl_wr),
        .wr_idx     (exp_wr_idx),
        .wr_reg     (exp_wr_reg),
        .wr_data    (exp_wr_data),
        .clear_hits (clear_hits),
        .set_hit    (set_hit),
        .set_idx    (match_idx),
        .count      (count_q),
        .ev_reg     (wb_reg),
        .ev_data    (wb_data),
        .rd_idx     (ptr),
        .rd_reg     (rd_reg),
        .rd_data    (rd_data),
        .match_any  (match_any),
        .match_idx  (match_idx),
        .unhit_idx  (unhit_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            count_q      <= '0;
            ptr          <= '0;
            match_cnt    <= '0;
            mismatch_cnt <= '0;
            cycle_cnt    <= '0;
            pass         <= 1'b0;
            fail         <= 1'b0;
            fail_idx     <= '0;
            fail_data    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        count_q      <= exp_count;
                        ptr          <= '0;
                        match_cnt    <= '0;
                        mismatch_cnt <= '0;
                        cycle_cnt    <= '0;
                        fail         <= 1'b0;
                        fail_idx     <= '0;
                        fail_data    <= '0;
                        if (exp_count == '0) begin
                            state <= DONE;
                            pass  <= 1'b1;
                        end else begin
                            state <= RUN;
                            pass  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (cycle_cnt != '1) begin
                        cycle_cnt <= cycle_cnt + 32'd1;
                    end
                    if (hit_ok) begin
                        match_cnt <= match_cnt + CW'(1);
                        ptr       <= ptr + IW'(1);
                    end
                    if (miss && mismatch_cnt != '1) begin
                        mismatch_cnt <= mismatch_cnt + 16'd1;
                    end
                    // Priority: completion, then data mismatch, then timeout.
                    if (completing) begin
                        state <= DONE;
                        pass  <= 1'b1;
                    end else if (bad_data) begin
                        state     <= DONE;
                        fail      <= 1'b1;
                        fail_idx  <= ptr;
                        fail_data <= wb_data;
                    end else if (timed_out) begin
                        state     <= DONE;
                        fail      <= 1'b1;
                        fail_idx  <= (ORDERED != 0) ? ptr : unhit_idx;
                        fail_data <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
